// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the external SRAM controller: FSM state encoding,
// default wait-state constants and byte-lane helpers.
package sram_ctrl_pkg;

   // Default access timing, in sys_clk cycles
   localparam int unsigned SRAM_RD_WAIT_DFLT = 2;
   localparam int unsigned SRAM_WR_WAIT_DFLT = 2;

   // Default SRAM word-address width
   localparam int unsigned SRAM_AW_DFLT = 18;

   // Controller sequencing states (3-bit encoding)
   typedef enum logic [2:0] {
      SRAM_IDLE      = 3'd0,
      SRAM_RD_ACCESS = 3'd1,
      SRAM_RD_LATCH  = 3'd2,
      SRAM_WR_SETUP  = 3'd3,
      SRAM_WR_PULSE  = 3'd4,
      SRAM_WR_HOLD   = 3'd5
   } sram_state_t;

   // Select the addressed byte out of a 16-bit SRAM word (upper = 1 -> [15:8])
   function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic upper);
      return upper ? word[15:8] : word[7:0];
   endfunction

endpackage : sram_ctrl_pkg

// File: rtl/sram_ctrl.sv
// Asynchronous external SRAM controller. Accepts single-byte CPU reads and
// writes qualified by cs, sequences the 16-bit SRAM strobes with
// parameterised wait states and stalls the CPU via ready until the access
// completes. The pad tristate is built one level up from dq_out/dq_oe.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned RD_WAIT = SRAM_RD_WAIT_DFLT,
   parameter int unsigned WR_WAIT = SRAM_WR_WAIT_DFLT,
   parameter int unsigned SRAM_AW = SRAM_AW_DFLT
) (
   input  logic               sys_clk,
   input  logic               reset_n,
   input  logic               cs,
   input  logic [15:0]        cpu_addr,
   input  logic               rd_req,
   input  logic               wr_en,
   input  logic [7:0]         wr_data,
   output logic [7:0]         rd_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   input  logic [15:0]        sram_dq_in,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n
);

   localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int unsigned CNT_W    = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

   sram_state_t      state;
   logic [CNT_W-1:0] wait_cnt;
   logic             lane;      // 1 = upper byte of the addressed word

   // Access sequencer: every strobe is registered so the SRAM pins never glitch
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state       <= SRAM_IDLE;
         wait_cnt    <= '0;
         lane        <= 1'b0;
         rd_data     <= '0;
         ready       <= 1'b1;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_ub_n   <= 1'b1;
         sram_lb_n   <= 1'b1;
      end else begin
         case (state)
            SRAM_IDLE: begin
               // Write wins over a simultaneous read request
               if (cs && wr_en) begin
                  state       <= SRAM_WR_SETUP;
                  wait_cnt    <= '0;
                  lane        <= cpu_addr[0];
                  ready       <= 1'b0;
                  sram_addr   <= SRAM_AW'(cpu_addr[15:1]);
                  sram_dq_out <= {wr_data, wr_data};
                  sram_dq_oe  <= 1'b1;
                  sram_ce_n   <= 1'b0;
                  sram_oe_n   <= 1'b1;
                  sram_we_n   <= 1'b1;
                  sram_ub_n   <= ~cpu_addr[0];
                  sram_lb_n   <= cpu_addr[0];
               end else if (cs && rd_req) begin
                  state      <= SRAM_RD_ACCESS;
                  wait_cnt   <= '0;
                  lane       <= cpu_addr[0];
                  ready      <= 1'b0;
                  sram_addr  <= SRAM_AW'(cpu_addr[15:1]);
                  sram_dq_oe <= 1'b0;
                  sram_ce_n  <= 1'b0;
                  sram_oe_n  <= 1'b0;
                  sram_we_n  <= 1'b1;
                  sram_ub_n  <= ~cpu_addr[0];
                  sram_lb_n  <= cpu_addr[0];
               end
            end

            SRAM_RD_ACCESS: begin
               if (wait_cnt == RD_LAST) begin
                  state    <= SRAM_RD_LATCH;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            SRAM_RD_LATCH: begin
               rd_data   <= lane_byte(sram_dq_in, lane);
               state     <= SRAM_IDLE;
               ready     <= 1'b1;
               sram_ce_n <= 1'b1;
               sram_oe_n <= 1'b1;
               sram_ub_n <= 1'b1;
               sram_lb_n <= 1'b1;
            end

            SRAM_WR_SETUP: begin
               state     <= SRAM_WR_PULSE;
               wait_cnt  <= '0;
               sram_we_n <= 1'b0;
            end

            SRAM_WR_PULSE: begin
               if (wait_cnt == WR_LAST) begin
                  state     <= SRAM_WR_HOLD;
                  wait_cnt  <= '0;
                  sram_we_n <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            SRAM_WR_HOLD: begin
               // Data, address and ce stay driven for one cycle after we_n rises
               state      <= SRAM_IDLE;
               ready      <= 1'b1;
               sram_dq_oe <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_ub_n  <= 1'b1;
               sram_lb_n  <= 1'b1;
            end

            default: begin
               state      <= SRAM_IDLE;
               wait_cnt   <= '0;
               ready      <= 1'b1;
               sram_dq_oe <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_oe_n  <= 1'b1;
               sram_we_n  <= 1'b1;
               sram_ub_n  <= 1'b1;
               sram_lb_n  <= 1'b1;
            end
         endcase
      end
   end

endmodule : sram_ctrl

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: an asynchronous SRAM device model on the
// pad side, and a CPU-level byte-array reference that predicts read data,
// access latency and strobe activity from the controller's timing rules.
module tb_sram_ctrl;

   localparam int unsigned RD_WAIT = 2;
   localparam int unsigned WR_WAIT = 2;
   localparam int unsigned SRAM_AW = 18;

   logic               sys_clk = 1'b0;
   logic               reset_n;
   logic               cs;
   logic [15:0]        cpu_addr;
   logic               rd_req;
   logic               wr_en;
   logic [7:0]         wr_data;
   logic [7:0]         rd_data;
   logic               ready;
   logic [SRAM_AW-1:0] sram_addr;
   logic [15:0]        sram_dq_in;
   logic [15:0]        sram_dq_out;
   logic               sram_dq_oe;
   logic               sram_ce_n;
   logic               sram_oe_n;
   logic               sram_we_n;
   logic               sram_ub_n;
   logic               sram_lb_n;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // CPU-view reference: one byte per CPU address
   logic [7:0]  ref_mem [0:65535];
   // SRAM device contents, updated only by the controller's strobes
   logic [15:0] dev_mem [0:32767];
   logic        dev_armed = 1'b0;
   logic [7:0]  last_rd;

   sram_ctrl #(
      .RD_WAIT (RD_WAIT),
      .WR_WAIT (WR_WAIT),
      .SRAM_AW (SRAM_AW)
   ) dut (
      .sys_clk     (sys_clk),
      .reset_n     (reset_n),
      .cs          (cs),
      .cpu_addr    (cpu_addr),
      .rd_req      (rd_req),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n),
      .sram_ub_n   (sram_ub_n),
      .sram_lb_n   (sram_lb_n)
   );

   always #5 sys_clk = ~sys_clk;

   // SRAM device: drives the word while selected and output-enabled
   assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? dev_mem[sram_addr[14:0]] : 16'hDEAD;

   // SRAM device: latches enabled byte lanes on the rising edge of we_n
   always @(posedge sram_we_n) begin
      if (dev_armed && !sram_ce_n) begin
         if (!sram_ub_n) dev_mem[sram_addr[14:0]][15:8] = sram_dq_out[15:8];
         if (!sram_lb_n) dev_mem[sram_addr[14:0]][7:0]  = sram_dq_out[7:0];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // One CPU access presented now (just after an edge); returns once ready rises
   task automatic do_access(input logic rq, input logic wq, input logic [15:0] a, input logic [7:0] d);
      int unsigned lat     = 0;
      int unsigned we_low  = 0;
      int unsigned exp_lat = wq ? (WR_WAIT + 3) : (RD_WAIT + 2);
      logic        ub_low  = 1'b0;
      logic        lb_low  = 1'b0;
      logic        oe_low  = 1'b0;
      logic        overlap = 1'b0;
      logic [31:0] addr_seen = '0;
      logic        is_rd   = rq && !wq;

      cs       = 1'b1;
      rd_req   = rq;
      wr_en    = wq;
      cpu_addr = a;
      wr_data  = d;
      for (int n = 1; n <= 40; n++) begin
         @(posedge sys_clk);
         #1;
         if (n == 1) begin
            cs     = 1'b0;
            rd_req = 1'b0;
            wr_en  = 1'b0;
            addr_seen = 32'(sram_addr);
         end
         if (!sram_we_n) we_low++;
         if (!sram_ub_n) ub_low = 1'b1;
         if (!sram_lb_n) lb_low = 1'b1;
         if (!sram_oe_n) oe_low = 1'b1;
         if (!sram_oe_n && sram_dq_oe) overlap = 1'b1;
         if (ready) begin
            lat = n;
            break;
         end
      end

      check_val("latency", lat, exp_lat);
      check_val("word_addr", addr_seen, {17'd0, a[15:1]});
      check_val("lane_enables", {30'd0, ub_low, lb_low}, {30'd0, a[0], ~a[0]});
      check_val("we_low_cycles", we_low, wq ? WR_WAIT : 0);
      check_val("oe_used", {31'd0, oe_low}, {31'd0, is_rd});
      check_val("oe_dq_oe_overlap", {31'd0, overlap}, 32'd0);
      check_val("idle_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);

      if (wq) begin
         ref_mem[a] = d;
         check_val("rd_data_hold", {24'd0, rd_data}, {24'd0, last_rd});
      end else begin
         check_val("rd_data", {24'd0, rd_data}, {24'd0, ref_mem[a]});
         last_rd = ref_mem[a];
      end
   endtask

   initial begin
      logic        saw_we;
      logic        stray;
      logic [15:0] ra;
      int unsigned op;

      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
      ref_mem[16'h0080] = 8'h34;
      ref_mem[16'h0081] = 8'h12;
      for (int w = 0; w < 32768; w++) dev_mem[w] = {ref_mem[2*w+1], ref_mem[2*w]};

      reset_n  = 1'b0;
      cs       = 1'b0;
      rd_req   = 1'b0;
      wr_en    = 1'b0;
      cpu_addr = '0;
      wr_data  = '0;
      last_rd  = '0;

      // Reset state
      tick(3);
      check_val("rst_ready", {31'd0, ready}, 32'd1);
      check_val("rst_rd_data", {24'd0, rd_data}, 32'd0);
      check_val("rst_addr", 32'(sram_addr), 32'd0);
      check_val("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
      check_val("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      check_val("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
      reset_n   = 1'b1;
      dev_armed = 1'b1;

      // Low and high byte reads of word 0x0040
      do_access(1'b1, 1'b0, 16'h0080, 8'h00);
      do_access(1'b1, 1'b0, 16'h0081, 8'h00);

      // Write upper byte at 0x7FFF, low byte of that word must be untouched
      do_access(1'b0, 1'b1, 16'h7FFF, 8'hA5);
      check_val("low_byte_intact", {24'd0, dev_mem[15'h3FFF][7:0]}, {24'd0, ref_mem[16'h7FFE]});
      tick(1);
      do_access(1'b1, 1'b0, 16'h7FFF, 8'h00);
      do_access(1'b1, 1'b0, 16'h7FFE, 8'h00);

      // Back-to-back write then read with no idle cycle in between
      do_access(1'b0, 1'b1, 16'h0100, 8'h5A);
      do_access(1'b1, 1'b0, 16'h0100, 8'h00);

      // Simultaneous read and write: write wins, no read capture
      do_access(1'b1, 1'b1, 16'h0002, 8'hC3);
      do_access(1'b1, 1'b0, 16'h0002, 8'h00);

      // Requests with cs=0 are ignored
      cs       = 1'b0;
      rd_req   = 1'b1;
      wr_en    = 1'b1;
      cpu_addr = 16'h0080;
      stray    = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick(1);
         if (!ready || !sram_ce_n || !sram_we_n || !sram_oe_n) stray = 1'b1;
      end
      rd_req = 1'b0;
      wr_en  = 1'b0;
      check_val("cs_gating", {31'd0, stray}, 32'd0);

      // Reset during the write pulse
      do_access(1'b1, 1'b0, 16'h0081, 8'h00);
      cs       = 1'b1;
      wr_en    = 1'b1;
      cpu_addr = 16'h0300;
      wr_data  = 8'h77;
      tick(1);
      cs     = 1'b0;
      wr_en  = 1'b0;
      saw_we = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (!sram_we_n) begin
            saw_we = 1'b1;
            break;
         end
         tick(1);
      end
      check_val("mid_write_pulse", {31'd0, saw_we}, 32'd1);
      reset_n = 1'b0;
      tick(1);
      check_val("rst_mid_strobes", {28'd0, sram_we_n, sram_ce_n, sram_dq_oe, ready}, 32'hD);
      check_val("rst_mid_rd_data", {24'd0, rd_data}, 32'd0);
      reset_n = 1'b1;
      last_rd = 8'h00;
      // The truncated write may or may not have landed; re-establish the byte
      do_access(1'b0, 1'b1, 16'h0300, 8'h77);
      do_access(1'b1, 1'b0, 16'h0300, 8'h00);

      // Randomised traffic over a small address window
      for (int k = 0; k < 40; k++) begin
         ra = 16'h0200 + 16'($urandom_range(0, 15));
         op = $urandom_range(0, 3);
         case (op)
            0, 1:    do_access(1'b1, 1'b0, ra, 8'h00);
            2:       do_access(1'b0, 1'b1, ra, 8'($urandom));
            default: do_access(1'b1, 1'b1, ra, 8'($urandom));
         endcase
         tick($urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sram_ctrl
